// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction-memory load controller
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [31:0] INST_NOP    = 32'h00000013;
  localparam int unsigned WORD_STRIDE = 4;
  localparam int unsigned WORD_SHIFT  = $clog2(WORD_STRIDE);

endpackage

// File: rtl/imem_load_ctrl_if.sv
// rtl/imem_load_ctrl_if.sv - loader, fetch and ROM signals of imem_load_ctrl
// slave is the controller's view; master is the loader/core/ROM environment's view.
interface imem_load_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 9
);

  logic              load_start;
  logic              load_valid;
  logic [31:0]       load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_done;
  logic              load_overflow;
  logic [CNT_W-1:0]  load_count;
  logic [31:0]       load_checksum;
  logic              cpu_run;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_valid;
  logic [31:0]       fetch_inst;
  logic              fetch_fault;
  logic              rom_write_en;
  logic [ADDR_W-1:0] rom_wr_addr;
  logic [31:0]       rom_wr_inst;
  logic              rom_read_en;
  logic [ADDR_W-1:0] rom_rd_addr;
  logic [31:0]       rom_rd_inst;

  modport slave (
    input  load_start, load_valid, load_data, load_last,
    input  fetch_req, fetch_addr, rom_rd_inst,
    output load_ready, load_done, load_overflow, load_count, load_checksum, cpu_run,
    output fetch_valid, fetch_inst, fetch_fault,
    output rom_write_en, rom_wr_addr, rom_wr_inst, rom_read_en, rom_rd_addr
  );

  modport master (
    output load_start, load_valid, load_data, load_last,
    output fetch_req, fetch_addr, rom_rd_inst,
    input  load_ready, load_done, load_overflow, load_count, load_checksum, cpu_run,
    input  fetch_valid, fetch_inst, fetch_fault,
    input  rom_write_en, rom_wr_addr, rom_wr_inst, rom_read_en, rom_rd_addr
  );

endinterface

// File: rtl/imem_fetch_stage.sv
// rtl/imem_fetch_stage.sv - one-cycle fetch register with fault check and NOP substitution
module imem_fetch_stage
  import imem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [ADDR_W-1:0] i_limit,
  input  logic [31:0]       i_rom_inst,
  output logic              o_valid,
  output logic [31:0]       o_inst,
  output logic              o_fault
);

  logic        r_valid;
  logic        r_fault;
  logic [31:0] r_inst;
  logic        w_fault;

  // i_limit is the byte size of the loaded image; anything at or past it is unwritten ROM
  assign w_fault = (i_addr[1:0] != 2'b00) || (i_addr >= i_limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_fault <= 1'b0;
      r_inst  <= 32'h0;
    end else begin
      r_valid <= i_req;
      r_fault <= i_req && w_fault;
      if (i_req) begin
        r_inst <= w_fault ? INST_NOP : i_rom_inst;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_inst  = r_inst;
  assign o_fault = r_fault;

endmodule

// File: rtl/imem_load_ctrl.sv
// rtl/imem_load_ctrl.sv - streams a program image into the instruction ROM, then releases the CPU
// Define IMEM_CHECKSUM_EN to build the running load_checksum adder.
module imem_load_ctrl
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 9
) (
  input  logic             clk,
  input  logic             rst,
  imem_load_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH_WORDS);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;
  logic              r_run;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wr_inst;

  logic              w_ready;
  logic              w_accept;
  logic              w_drop;
  logic              w_fetch;
  logic [ADDR_W-1:0] w_limit;

  // load_start pre-empts whatever word is on the bus in the same cycle
  assign w_ready  = (r_state == LOAD) && (r_count < FULL_CNT);
  assign w_accept = (r_state == LOAD) && !bus.load_start && bus.load_valid && w_ready;
  assign w_drop   = (r_state == LOAD) && !bus.load_start && bus.load_valid && !w_ready;
  assign w_fetch  = (r_state == RUN) && bus.fetch_req;
  assign w_limit  = ADDR_W'(r_count) << WORD_SHIFT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (bus.load_start) w_next = LOAD;
      LOAD: begin
        if (bus.load_start) begin
          w_next = LOAD;
        end else if ((w_accept && bus.load_last) || w_drop) begin
          w_next = RUN;
        end
      end
      RUN:  if (bus.load_start) w_next = LOAD;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.load_ready  = w_ready;
    bus.rom_read_en = w_fetch;
    bus.rom_rd_addr = w_fetch ? bus.fetch_addr : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_run      <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_inst  <= 32'h0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_wr_addr <= w_limit;
        r_wr_inst <= bus.load_data;
      end
      if (bus.load_start) begin
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_accept) r_count <= r_count + CNT_W'(1);
        if (w_drop)   r_overflow <= 1'b1;
      end
      // Lags state entry by one edge so the CPU wakes after the final write pulse
      r_run <= (r_state == RUN) && (w_next == RUN);
    end
  end

`ifdef IMEM_CHECKSUM_EN
  logic [31:0] r_checksum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_checksum <= 32'h0;
    end else if (bus.load_start) begin
      r_checksum <= 32'h0;
    end else if (w_accept) begin
      r_checksum <= r_checksum + bus.load_data;
    end
  end

  assign bus.load_checksum = r_checksum;
`else
  assign bus.load_checksum = 32'h0;
`endif

  assign bus.load_count    = r_count;
  assign bus.load_overflow = r_overflow;
  assign bus.load_done     = r_run;
  assign bus.cpu_run       = r_run;
  assign bus.rom_write_en  = r_wr_en;
  assign bus.rom_wr_addr   = r_wr_addr;
  assign bus.rom_wr_inst   = r_wr_inst;

  imem_fetch_stage #(
    .ADDR_W(ADDR_W)
  ) u_fetch (
    .clk        (clk),
    .rst        (rst),
    .i_req      (w_fetch),
    .i_addr     (bus.fetch_addr),
    .i_limit    (w_limit),
    .i_rom_inst (bus.rom_rd_inst),
    .o_valid    (bus.fetch_valid),
    .o_inst     (bus.fetch_inst),
    .o_fault    (bus.fetch_fault)
  );

endmodule
